// File: rtl/fifo_init_pkg.sv
// Shared types and helpers for the FIFO post-reset initialisation sequencer.
package fifo_init_pkg;

    typedef enum logic [1:0] {
        S_RST     = 2'd0,
        S_CLEAR   = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } init_state_e;

    // Every RAM word is written with copies of this bit during the clear walk.
    localparam logic CLEAR_BIT = 1'b0;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << res) < value) begin
                res = res + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_init_seq.sv
// Post-reset initialisation sequencer: zero-fills the FIFO RAM, then releases
// the per-stage active-low resets one by one with a fixed gap, then reports done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RST     | global reset held or just released; outputs at reset values
// S_CLEAR   | writing zero to one RAM word per clock, address 0..DEPTH-1
// S_RELEASE | counting hold gaps and releasing stage resets in order
// S_DONE    | all stages released; waits here until reset or soft reset
module fifo_init_seq
    import fifo_init_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_soft_rst,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [NUM_STAGES-1:0] o_stage_rst_n,
    output logic                  o_init_busy,
    output logic                  o_init_done
);

    localparam int CNT_W = clog2(HOLD_CYCLES) + 1;
    localparam int IDX_W = clog2(NUM_STAGES) + 1;

    localparam logic [CNT_W-1:0]      HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]      STAGE_LAST = IDX_W'(NUM_STAGES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] CLEAR_WORD = {DATA_WIDTH{CLEAR_BIT}};

    init_state_e           state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // State and registered outputs; global reset returns everything to the idle values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_RST;
            wr_en_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            stage_rst_n_q <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            cnt_q         <= '0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            stage_rst_n_q <= stage_rst_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
        end
    end

    // Next-state and next-output logic; soft reset overrides every state except S_RST.
    always_comb begin
        state_d       = state_q;
        wr_en_d       = wr_en_q;
        addr_d        = addr_q;
        wdata_d       = CLEAR_WORD;
        stage_rst_n_d = stage_rst_n_q;
        busy_d        = busy_q;
        done_d        = done_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;

        case (state_q)
            S_RST: begin
                state_d = S_CLEAR;
                wr_en_d = 1'b1;
                addr_d  = '0;
                cnt_d   = '0;
                idx_d   = '0;
            end
            S_CLEAR: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_RELEASE;
                    wr_en_d = 1'b0;
                    addr_d  = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            stage_rst_n_d[k] = 1'b1;
                        end
                    end
                    if (idx_q == STAGE_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_RST;
            end
        endcase

        // Restart the whole walk without touching the global reset; while held,
        // address 0 is rewritten every cycle.
        if (i_soft_rst && (state_q != S_RST)) begin
            state_d       = S_CLEAR;
            wr_en_d       = 1'b1;
            addr_d        = '0;
            stage_rst_n_d = '0;
            busy_d        = 1'b1;
            done_d        = 1'b0;
            cnt_d         = '0;
            idx_d         = '0;
        end
    end

    assign o_mem_wr_en   = wr_en_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_wdata   = wdata_q;
    assign o_stage_rst_n = stage_rst_n_q;
    assign o_init_busy   = busy_q;
    assign o_init_done   = done_q;

endmodule

// File: tb/tb_fifo_init_seq.sv
// Bench for fifo_init_seq: a default-parameter instance and a minimal one
// (ADDR_WIDTH=2, NUM_STAGES=1, HOLD_CYCLES=1) run side by side against a
// position-in-sequence model.
module tb_fifo_init_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_a, soft_b;

    logic       wr_a, busy_a, done_a;
    logic [3:0] addr_a;
    logic [7:0] wdata_a;
    logic [2:0] srn_a;

    logic       wr_b, busy_b, done_b;
    logic [1:0] addr_b;
    logic [7:0] wdata_b;
    logic [0:0] srn_b;

    int n_checks = 0;
    int n_errors = 0;

    // Edges since the sequence last started (0 = held in reset).
    int p_a = 0;
    int p_b = 0;

    always #5 clk = ~clk;

    fifo_init_seq dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_soft_rst   (soft_a),
        .o_mem_wr_en  (wr_a),
        .o_mem_addr   (addr_a),
        .o_mem_wdata  (wdata_a),
        .o_stage_rst_n(srn_a),
        .o_init_busy  (busy_a),
        .o_init_done  (done_a)
    );

    fifo_init_seq #(
        .ADDR_WIDTH (2),
        .DATA_WIDTH (8),
        .NUM_STAGES (1),
        .HOLD_CYCLES(1)
    ) dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_soft_rst   (soft_b),
        .o_mem_wr_en  (wr_b),
        .o_mem_addr   (addr_b),
        .o_mem_wdata  (wdata_b),
        .o_stage_rst_n(srn_b),
        .o_init_busy  (busy_b),
        .o_init_done  (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs derived from the sequence position p:
    // writes occupy positions 1..depth, stage k is out of reset from position
    // depth+1+(k+1)*hold onward, done once every stage is out.
    task automatic check_outputs(input string nm, input int p, input int depth,
                                 input int hold, input int nst,
                                 input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] srn,
                                 input logic busy, input logic done);
        int   released;
        logic exp_wr;
        logic exp_done;
        exp_wr   = (p >= 1) && (p <= depth);
        released = (p > depth) ? (p - depth - 1) / hold : 0;
        if (released > nst) released = nst;
        exp_done = (released == nst);
        chk({nm, "_wr_en"}, 32'(wr), 32'(exp_wr));
        chk({nm, "_addr"}, addr, exp_wr ? 32'(p - 1) : 32'd0);
        chk({nm, "_wdata"}, wdata, 32'd0);
        chk({nm, "_stage_rst_n"}, srn, 32'((1 << released) - 1));
        chk({nm, "_done"}, 32'(done), 32'(exp_done));
        chk({nm, "_busy"}, 32'(busy), 32'(!exp_done));
    endtask

    task automatic check_both();
        check_outputs("a", p_a, 16, 4, 3, wr_a, 32'(addr_a), 32'(wdata_a), 32'(srn_a), busy_a, done_a);
        check_outputs("b", p_b, 4, 1, 1, wr_b, 32'(addr_b), 32'(wdata_b), 32'(srn_b), busy_b, done_b);
    endtask

    // One rising edge: advance the model with the inputs that edge sees, then compare.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            p_a = 0;
            p_b = 0;
        end else begin
            p_a = soft_a ? 1 : ((p_a < 10000) ? p_a + 1 : p_a);
            p_b = soft_b ? 1 : ((p_b < 10000) ? p_b + 1 : p_b);
        end
        #1;
        check_both();
    endtask

    initial begin
        int n_wr;
        int done_edge_a;
        int done_edge_b;
        int seen;

        rst    = 1'b1;
        soft_a = 1'b0;
        soft_b = 1'b0;
        #12;
        check_both();
        @(negedge clk);
        rst = 1'b0;

        // Scenario 1: default run from reset release, record write count and done edge.
        n_wr        = 0;
        done_edge_a = 0;
        done_edge_b = 0;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (wr_a) n_wr++;
            if (done_a && done_edge_a == 0) done_edge_a = e;
            if (done_b && done_edge_b == 0) done_edge_b = e;
        end
        chk("s1_write_count", 32'(n_wr), 32'd16);
        chk("s1_done_edge", 32'(done_edge_a), 32'd29);
        chk("s6_done_edge", 32'(done_edge_b), 32'd6);

        // Scenario 2: one-cycle soft reset from S_DONE.
        soft_a = 1'b1;
        step();
        soft_a = 1'b0;
        chk("s2_srn_drop", 32'(srn_a), 32'd0);
        chk("s2_done_drop", 32'(done_a), 32'd0);
        repeat (35) step();

        // Scenario 3: soft reset in S_CLEAR while the address is 9.
        soft_a = 1'b1;
        step();
        soft_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step();
            if (addr_a == 4'd9 && wr_a) seen = 1;
        end
        chk("s3_reached_addr9", 32'(seen), 32'd1);
        soft_a = 1'b1;
        step();
        soft_a = 1'b0;
        chk("s3_addr_restart", 32'(addr_a), 32'd0);
        n_wr = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (wr_a) n_wr++;
        end
        chk("s3_write_count", 32'(n_wr), 32'd16);

        // Scenario 4: soft reset held five cycles during S_RELEASE.
        soft_a = 1'b1;
        step();
        soft_a = 1'b0;
        repeat (18) step();
        soft_a = 1'b1;
        repeat (5) begin
            step();
            chk("s4_hold_addr", 32'(addr_a), 32'd0);
        end
        soft_a = 1'b0;
        repeat (35) step();

        // Scenario 5: async reset between edges while stage 1 is pending.
        soft_a = 1'b1;
        step();
        soft_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            step();
            if (p_a == 22) seen = 1;
        end
        chk("s5_stage0_only", 32'(srn_a), 32'd1);
        #3;
        rst = 1'b1;
        p_a = 0;
        p_b = 0;
        #1;
        check_both();
        @(negedge clk);
        rst = 1'b0;
        done_edge_a = 0;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (done_a && done_edge_a == 0) done_edge_a = e;
        end
        chk("s5_done_edge", 32'(done_edge_a), 32'd29);

        // Random soft-reset pulses on both instances.
        for (int i = 0; i < 400; i++) begin
            soft_a = ($urandom_range(0, 24) == 0);
            soft_b = ($urandom_range(0, 6) == 0);
            step();
        end
        soft_a = 1'b0;
        soft_b = 1'b0;
        repeat (40) step();
        chk("final_done_a", 32'(done_a), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
